snake_head_stepper: RTL

- Downstream consumer of the 20-bit tick counter's `count` output.
- Detects each counter roll-over (count returns to 0) and turns it into one game step.
- On each step, moves the snake head one cell on a wrapping grid in the committed direction.
- Owns the latched direction, with reversal protection, and the IDLE/RUN/DEAD game-state FSM that drives the body/render stages.

---
 rtl/snake_pkg.sv | 33 +++
 rtl/snake_tick_detect.sv | 25 ++
 rtl/snake_head_stepper.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared encodings for the snake pipeline: directions, game states and button bundle.
package snake_pkg;

    localparam int unsigned TICK_W = 20;
    localparam int unsigned DIR_W  = 2;
    localparam int unsigned ST_W   = 2;

    typedef enum logic [DIR_W-1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } btn_t;

    // Opposite directions differ only in the upper encoding bit.
    function automatic dir_e dir_reverse(input dir_e d);
        return dir_e'(d ^ DIR_W'(2'b10));
    endfunction

endpackage

// File: rtl/snake_tick_detect.sv
// Turns each roll-over of the tick counter (non-zero back to zero) into a one-cycle event.
module snake_tick_detect
    import snake_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic [TICK_W-1:0] i_tick_count,
    output logic              o_tick_evt_c
);

    logic w_is_zero;
    logic r_prev_nz;

    assign w_is_zero    = (i_tick_count == '0);
    assign o_tick_evt_c = w_is_zero && r_prev_nz;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_nz <= 1'b0;
        end else begin
            r_prev_nz <= !w_is_zero;
        end
    end

endmodule

// File: rtl/snake_head_stepper.sv
// Snake head stepper: latches direction with reversal protection, moves the head on a
// wrapping grid once per tick roll-over, and runs the IDLE/RUN/DEAD game FSM.
module snake_head_stepper
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W  = 32,
    parameter int unsigned GRID_H  = 24,
    parameter int unsigned X_W     = 5,
    parameter int unsigned Y_W     = 5,
    parameter int unsigned START_X = 16,
    parameter int unsigned START_Y = 12
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [TICK_W-1:0] tick_count,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              start,
    input  logic              collision,
    output logic [X_W-1:0]    head_x,
    output logic [Y_W-1:0]    head_y,
    output logic [DIR_W-1:0]  dir,
    output logic              step,
    output logic [ST_W-1:0]   state,
    output logic              game_over
);

    localparam logic [X_W-1:0] X_INIT = X_W'(START_X);
    localparam logic [Y_W-1:0] Y_INIT = Y_W'(START_Y);
    localparam logic [X_W-1:0] X_MAX  = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_MAX  = Y_W'(GRID_H - 1);

    state_e         r_state, w_state_nxt;
    logic [X_W-1:0] r_x, w_x_nxt, w_x_mv;
    logic [Y_W-1:0] r_y, w_y_nxt, w_y_mv;
    dir_e           r_dir, w_dir_nxt;
    dir_e           r_pend, w_pend_nxt;
    logic           r_step, w_step_nxt;
    logic           r_game_over, w_game_over_nxt;

    btn_t           w_btn;
    logic           w_req_vld;
    dir_e           w_req_dir;
    logic           w_req_ok;
    dir_e           w_new_dir;
    logic           w_tick_evt;

    snake_tick_detect u_tick_detect (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_tick_count (tick_count),
        .o_tick_evt_c (w_tick_evt)
    );

    assign w_btn = '{up: btn_up, down: btn_down, left: btn_left, right: btn_right};

    // Single highest-priority request; a rejected reversal does not fall through.
    always_comb begin
        w_req_vld = 1'b1;
        w_req_dir = DIR_UP;
        if (w_btn.up) begin
            w_req_dir = DIR_UP;
        end else if (w_btn.down) begin
            w_req_dir = DIR_DOWN;
        end else if (w_btn.left) begin
            w_req_dir = DIR_LEFT;
        end else if (w_btn.right) begin
            w_req_dir = DIR_RIGHT;
        end else begin
            w_req_vld = 1'b0;
        end
    end

    assign w_req_ok  = w_req_vld && (w_req_dir != dir_reverse(r_dir));
    assign w_new_dir = w_req_ok ? w_req_dir : r_pend;

    // Candidate head position one cell along the direction about to be committed.
    always_comb begin
        w_x_mv = r_x;
        w_y_mv = r_y;
        case (w_new_dir)
            DIR_RIGHT: w_x_mv = (r_x == X_MAX) ? '0 : r_x + X_W'(1);
            DIR_LEFT:  w_x_mv = (r_x == '0) ? X_MAX : r_x - X_W'(1);
            DIR_DOWN:  w_y_mv = (r_y == Y_MAX) ? '0 : r_y + Y_W'(1);
            DIR_UP:    w_y_mv = (r_y == '0) ? Y_MAX : r_y - Y_W'(1);
            default:   ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_dir_nxt   = r_dir;
        w_pend_nxt  = r_pend;
        w_step_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_x_nxt    = X_INIT;
                w_y_nxt    = Y_INIT;
                w_dir_nxt  = DIR_RIGHT;
                w_pend_nxt = DIR_RIGHT;
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (collision) begin
                    w_state_nxt = ST_DEAD;
                end else begin
                    if (w_req_ok) begin
                        w_pend_nxt = w_req_dir;
                    end
                    if (w_tick_evt) begin
                        w_dir_nxt  = w_new_dir;
                        w_pend_nxt = w_new_dir;
                        w_x_nxt    = w_x_mv;
                        w_y_nxt    = w_y_mv;
                        w_step_nxt = 1'b1;
                    end
                end
            end
            ST_DEAD: begin
                if (start) begin
                    w_state_nxt = ST_IDLE;
                    w_x_nxt     = X_INIT;
                    w_y_nxt     = Y_INIT;
                    w_dir_nxt   = DIR_RIGHT;
                    w_pend_nxt  = DIR_RIGHT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_x_nxt     = X_INIT;
                w_y_nxt     = Y_INIT;
                w_dir_nxt   = DIR_RIGHT;
                w_pend_nxt  = DIR_RIGHT;
            end
        endcase
        w_game_over_nxt = (w_state_nxt == ST_DEAD);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_x         <= X_INIT;
            r_y         <= Y_INIT;
            r_dir       <= DIR_RIGHT;
            r_pend      <= DIR_RIGHT;
            r_step      <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_dir       <= w_dir_nxt;
            r_pend      <= w_pend_nxt;
            r_step      <= w_step_nxt;
            r_game_over <= w_game_over_nxt;
        end
    end

    assign head_x    = r_x;
    assign head_y    = r_y;
    assign dir       = r_dir;
    assign step      = r_step;
    assign state     = r_state;
    assign game_over = r_game_over;

endmodule
